// File: rtl/star_effect_pkg.sv
// Shared game definitions for the star effect: FSM states, screen geometry,
// the palette index type, and the procedural star sprite image.
package star_effect_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned COORD_W  = 10;
    localparam int unsigned PAL_W    = 4;
    localparam int unsigned LIFE_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLY   = 2'd1,
        BLINK = 2'd2
    } star_state_t;

    typedef logic [PAL_W-1:0] pal_idx_t;

    // Star sprite in the Kirby palette: 2 = core, 1 = axis rays, 3 = diagonal rays.
    function automatic pal_idx_t star_pixel(input logic [3:0] dy, input logic [3:0] dx);
        logic [2:0] cx;
        logic [2:0] cy;
        logic [3:0] r;
        cx = dx[3] ? dx[2:0] : ~dx[2:0];
        cy = dy[3] ? dy[2:0] : ~dy[2:0];
        r  = {1'b0, cx} + {1'b0, cy};
        if (r <= 4'd3)
            return pal_idx_t'(2);
        else if (cx == 3'd0 || cy == 3'd0)
            return pal_idx_t'(1);
        else if (cx == cy && cx <= 3'd4)
            return pal_idx_t'(3);
        else
            return pal_idx_t'(0);
    endfunction

endpackage

// File: rtl/star_rom.sv
// 256x4 synchronous-read star sprite ROM addressed {dy, dx}; the read data is
// cleared when en is low so the caller can mask off-box and idle pixels.
module star_rom
    import star_effect_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr,
    input  logic       en,
    output pal_idx_t   data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data <= '0;
        else if (en)
            data <= star_pixel(addr[7:4], addr[3:0]);
        else
            data <= '0;
    end

endmodule

// File: rtl/star_effect.sv
// Star projectile effect: spawned by a pulse, steps once per video frame,
// blinks near end of life, and returns a per-pixel palette index for the mapper.
module star_effect
    import star_effect_pkg::*;
#(
    parameter int unsigned STAR_W      = 16,
    parameter int unsigned STAR_H      = 16,
    parameter int unsigned LIFE_FRAMES = 60,
    parameter int unsigned BLINK_START = 40,
    parameter int unsigned STEP_X      = 3
)
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               spawn,
    input  logic [COORD_W-1:0] spawn_x,
    input  logic [COORD_W-1:0] spawn_y,
    input  logic               spawn_dir,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    output pal_idx_t           idx_star,
    output logic               Star_appear,
    output logic [COORD_W-1:0] star_x,
    output logic [COORD_W-1:0] star_y,
    output logic               busy
);

    star_state_t        state;
    logic [LIFE_W-1:0]  life_cnt;
    logic               dir;
    logic [2:0]         fsync;
    logic               tick;

    logic [LIFE_W-1:0]  life_nxt;
    logic [COORD_W-1:0] x_step;
    logic               off_edge;
    logic               vis;
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic               in_box;

    // Two-flop synchroniser plus one edge-history flop for the vsync level.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            fsync <= '0;
        else
            fsync <= {fsync[1:0], frame_clk};
    end

    assign tick = fsync[1] & ~fsync[2];

    // Per-frame step candidates; leaving the visible area ends the effect.
    always_comb begin
        life_nxt = life_cnt + LIFE_W'(1);
        x_step   = star_x;
        off_edge = 1'b0;
        if (dir) begin
            off_edge = (star_x < COORD_W'(STEP_X));
            x_step   = star_x - COORD_W'(STEP_X);
        end else begin
            off_edge = (({1'b0, star_x} + (COORD_W+1)'(STEP_X)) > (COORD_W+1)'(SCREEN_W - STAR_W));
            x_step   = star_x + COORD_W'(STEP_X);
        end
    end

    // Lifetime FSM; spawn overrides everything, including a coincident tick.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            life_cnt <= '0;
            star_x   <= '0;
            star_y   <= '0;
            dir      <= 1'b0;
        end else if (spawn) begin
            state    <= FLY;
            busy     <= 1'b1;
            life_cnt <= '0;
            star_x   <= spawn_x;
            star_y   <= spawn_y;
            dir      <= spawn_dir;
        end else if (tick && state != IDLE) begin
            life_cnt <= life_nxt;
            if (!off_edge)
                star_x <= x_step;
            if (off_edge || life_nxt == LIFE_W'(LIFE_FRAMES)) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (state == FLY && life_nxt == LIFE_W'(BLINK_START)) begin
                state <= BLINK;
            end
        end
    end

    assign vis = (state == FLY) || (state == BLINK && !life_cnt[2]);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            Star_appear <= 1'b0;
        else
            Star_appear <= vis;
    end

    // Pixel path: box test and ROM read share the single cycle of latency.
    assign dx     = DrawX - star_x;
    assign dy     = DrawY - star_y;
    assign in_box = (dx < COORD_W'(STAR_W)) && (dy < COORD_W'(STAR_H));

    star_rom u_rom (
        .clk  (Clk),
        .rst  (Reset),
        .addr ({dy[3:0], dx[3:0]}),
        .en   (in_box && state != IDLE),
        .data (idx_star)
    );

endmodule

// File: tb/tb_star_effect.sv
// Self-checking bench for star_effect: constant vector table, hand-written
// corner sequences, and randomized flights against a behavioural model.
module tb_star_effect;

    localparam int STEP  = 3;
    localparam int SW    = 16;
    localparam int SH    = 16;
    localparam int LIFE  = 60;
    localparam int BLINK = 40;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       spawn;
    logic [9:0] spawn_x;
    logic [9:0] spawn_y;
    logic       spawn_dir;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [3:0] idx_star;
    logic       Star_appear;
    logic [9:0] star_x;
    logic [9:0] star_y;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    int m_alive;
    int m_life;
    int m_x;
    int m_y;
    int m_dir;

    star_effect dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .spawn       (spawn),
        .spawn_x     (spawn_x),
        .spawn_y     (spawn_y),
        .spawn_dir   (spawn_dir),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .idx_star    (idx_star),
        .Star_appear (Star_appear),
        .star_x      (star_x),
        .star_y      (star_y),
        .busy        (busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int sx, sy, dir, ticks, px, py;
        int ex, ebusy, eidx, eapp;
    } vec_t;

    vec_t tbl[10];

    // Star drawn with odd distances from the sprite centre (7.5, 7.5).
    function automatic int ref_sprite(input int dx, input int dy);
        int ax, ay, r;
        ax = 2 * dx - 15;
        if (ax < 0) ax = -ax;
        ay = 2 * dy - 15;
        if (ay < 0) ay = -ay;
        r = (ax + ay - 2) / 2;
        if (r <= 3) return 2;
        if (ax == 1 || ay == 1) return 1;
        if (ax == ay && ax <= 9) return 3;
        return 0;
    endfunction

    function automatic int exp_idx(input int px, input int py);
        int dx, dy;
        dx = (px - m_x) & 1023;
        dy = (py - m_y) & 1023;
        if (m_alive == 0) return 0;
        if (dx < SW && dy < SH) return ref_sprite(dx, dy);
        return 0;
    endfunction

    function automatic int exp_appear();
        if (m_alive == 0) return 0;
        if (m_life >= BLINK && ((m_life / 4) % 2) == 1) return 0;
        return 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_spawn(input int x, input int y, input int d);
        m_alive = 1;
        m_life  = 0;
        m_x     = x;
        m_y     = y;
        m_dir   = d;
    endtask

    task automatic model_tick();
        int nx;
        if (m_alive != 0) begin
            m_life++;
            nx = (m_dir != 0) ? m_x - STEP : m_x + STEP;
            if (nx < 0 || nx > 640 - SW) m_alive = 0;
            else m_x = nx;
            if (m_life == LIFE) m_alive = 0;
        end
    endtask

    task automatic do_spawn(input int x, input int y, input int d);
        @(negedge Clk);
        spawn_x   = 10'(x);
        spawn_y   = 10'(y);
        spawn_dir = d[0];
        spawn     = 1'b1;
        @(negedge Clk);
        spawn     = 1'b0;
        model_spawn(x, y, d);
    endtask

    task automatic do_tick();
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        model_tick();
    endtask

    task automatic set_pixel(input int px, input int py);
        @(negedge Clk);
        DrawX = 10'(px);
        DrawY = 10'(py);
        @(negedge Clk);
    endtask

    initial begin
        Reset     = 1'b1;
        frame_clk = 1'b0;
        spawn     = 1'b0;
        spawn_x   = '0;
        spawn_y   = '0;
        spawn_dir = 1'b0;
        DrawX     = '0;
        DrawY     = '0;
        m_alive = 0; m_life = 0; m_x = 0; m_y = 0; m_dir = 0;

        //          sx   sy dir tk   px   py    ex busy idx app
        tbl[0] = '{100, 200, 0, 10, 138, 208, 130, 1, 2, 1};
        tbl[1] = '{100, 200, 0, 10, 146, 208, 130, 1, 0, 1};
        tbl[2] = '{  5,  50, 1,  1,   9,  50,   2, 1, 1, 1};
        tbl[3] = '{  5,  50, 1,  2,   9,  50,   2, 0, 0, 0};
        tbl[4] = '{622,  10, 0,  1, 622,  10, 622, 0, 0, 0};
        tbl[5] = '{621,   0, 0,  1, 632,   8, 624, 1, 2, 1};
        tbl[6] = '{300, 100, 0, 45, 440, 105, 435, 1, 3, 0};
        tbl[7] = '{300, 100, 0, 48, 450, 109, 444, 1, 2, 1};
        tbl[8] = '{300, 100, 0, 60, 480, 100, 480, 0, 0, 0};
        tbl[9] = '{  0,   0, 1,  0,   7,   0,   0, 1, 1, 1};

        repeat (3) @(negedge Clk);
        check("reset_busy", int'(busy), 0);
        check("reset_star_x", int'(star_x), 0);
        check("reset_star_y", int'(star_y), 0);
        check("reset_idx", int'(idx_star), 0);
        check("reset_appear", int'(Star_appear), 0);
        Reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_spawn(tbl[i].sx, tbl[i].sy, tbl[i].dir);
            for (int t = 0; t < tbl[i].ticks; t++) do_tick();
            set_pixel(tbl[i].px, tbl[i].py);
            check($sformatf("vec%0d_star_x", i), int'(star_x), tbl[i].ex);
            check($sformatf("vec%0d_star_y", i), int'(star_y), tbl[i].sy);
            check($sformatf("vec%0d_busy", i), int'(busy), tbl[i].ebusy);
            check($sformatf("vec%0d_idx", i), int'(idx_star), tbl[i].eidx);
            check($sformatf("vec%0d_appear", i), int'(Star_appear), tbl[i].eapp);
        end

        // Blink cadence and expiry across a whole lifetime.
        do_spawn(300, 100, 0);
        for (int t = 1; t <= LIFE; t++) begin
            do_tick();
            check($sformatf("life_appear_t%0d", t), int'(Star_appear), exp_appear());
            check($sformatf("life_busy_t%0d", t), int'(busy), m_alive);
        end

        // Asynchronous reset in the middle of a flight.
        do_spawn(100, 200, 0);
        for (int t = 0; t < 5; t++) do_tick();
        set_pixel(123, 208);
        check("prereset_idx", int'(idx_star), 2);
        #2 Reset = 1'b1;
        #1;
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_appear", int'(Star_appear), 0);
        check("async_reset_idx", int'(idx_star), 0);
        check("async_reset_star_x", int'(star_x), 0);
        @(negedge Clk);
        Reset = 1'b0;
        m_alive = 0; m_x = 0; m_y = 0; m_life = 0;

        // Spawn coinciding with a tick: spawn wins and the tick is lost.
        do_spawn(200, 100, 0);
        for (int t = 0; t < 30; t++) do_tick();
        check("race_pre_x", int'(star_x), 290);
        @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        spawn_x   = 10'd50;
        spawn_y   = 10'd50;
        spawn_dir = 1'b0;
        spawn     = 1'b1;
        @(negedge Clk);
        spawn     = 1'b0;
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        model_spawn(50, 50, 0);
        check("race_star_x", int'(star_x), 50);
        check("race_star_y", int'(star_y), 50);
        check("race_busy", int'(busy), 1);
        for (int t = 1; t <= 48; t++) begin
            do_tick();
            check($sformatf("race_x_t%0d", t), int'(star_x), m_x);
            check($sformatf("race_appear_t%0d", t), int'(Star_appear), exp_appear());
        end

        // Randomized flights with random retriggers and pixel probes.
        for (int it = 0; it < 25; it++) begin
            int n;
            do_spawn(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                     int'($urandom_range(0, 1)));
            n = int'($urandom_range(0, 65));
            for (int t = 0; t < n; t++) do_tick();
            check($sformatf("rnd%0d_star_x", it), int'(star_x), m_x);
            check($sformatf("rnd%0d_star_y", it), int'(star_y), m_y);
            check($sformatf("rnd%0d_busy", it), int'(busy), m_alive);
            for (int p = 0; p < 4; p++) begin
                int px, py;
                px = (m_x + int'($urandom_range(0, 19)) - 2) & 1023;
                py = (m_y + int'($urandom_range(0, 19)) - 2) & 1023;
                set_pixel(px, py);
                check($sformatf("rnd%0d_idx_%0d_%0d", it, px, py), int'(idx_star), exp_idx(px, py));
                check($sformatf("rnd%0d_appear", it), int'(Star_appear), exp_appear());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/star_effect.md
# star_effect

Star-projectile effect generator feeding the pixel colour mapper. It is launched by a one-cycle spawn pulse (Kirby spit / enemy defeat), flies horizontally once per video frame, blinks near end of life, then expires. Per pixel it returns the 4-bit palette index of the star sprite plus a global visibility flag (`idx_star`, `Star_appear`), which the mapper overlays above all other layers.

## Interface
- `STAR_W`, 16: sprite width in pixels (power of two, ≤16)
- `STAR_H`, 16: sprite height in pixels (power of two, ≤16)
- `LIFE_FRAMES`, 60: total frames alive (2..255)
- `BLINK_START`, 40: frame count at which blinking starts (< LIFE_FRAMES)
- `STEP_X`, 3: horizontal pixels moved per frame
- `Clk`  in  1  system clock; the only clock
- `Reset`  in  1  asynchronous, active-high reset
- `frame_clk`  in  1  vertical-sync level from the VGA controller (asynchronous)
- `spawn`  in  1  one-`Clk` launch pulse
- `spawn_x`, `spawn_y`  in  10 each  top-left of star at launch
- `spawn_dir`  in  1  0 = move right, 1 = move left
- `DrawX`, `DrawY`  in  10 each  current pixel coordinates
- `idx_star`  out  4  palette index; 0 = transparent
- `Star_appear`  out  1  star layer enabled this pixel
- `star_x`, `star_y`  out  10 each  current star top-left
- `busy`  out  1  effect active (state ≠ IDLE)

## Operation
- `frame_clk` passes through a 2-flop synchroniser; `tick` = one-`Clk` pulse on its synchronised rising edge.
- FSM states: IDLE, FLY, BLINK.
- `spawn` in any state: load `star_x/star_y` from the spawn inputs, latch direction, clear `life_cnt` (8-bit), go to FLY. Spawn while busy retriggers. Spawn and tick in the same cycle: spawn wins, and the tick is dropped.
- On `tick` in FLY or BLINK: `life_cnt` += 1. X moves by STEP_X in the latched direction.
- Off-screen rule: moving right with `star_x + STEP_X > 640 − STAR_W`, or moving left with `star_x < STEP_X`, goes to IDLE. Position is not updated and does not wrap.
- FLY → BLINK when the incremented `life_cnt` == BLINK_START.
- FLY/BLINK → IDLE when the incremented `life_cnt` == LIFE_FRAMES. This takes priority over the BLINK transition.
- Visibility: `vis` = (state == FLY) or (state == BLINK and `life_cnt[2]` == 0), giving a 4-frame on / 4-frame off blink.
- Pixel path:
  - `dx = DrawX − star_x`, `dy = DrawY − star_y`, 10-bit unsigned wrap.
  - `in_box` = `dx < STAR_W` and `dy < STAR_H`.
  - Sprite ROM address = {dy[3:0], dx[3:0]}.
  - `idx_star` = ROM data when `in_box`, else 0.
- `Star_appear` = `vis`, registered and aligned with `idx_star`.
- Position changes only on `tick` or `spawn`, so there is no mid-frame tearing from movement.

## Timing
- Reset (asynchronous, any time, including mid-flight):
  - state IDLE; `life_cnt`, `star_x`, `star_y`, and the direction latch all 0.
  - `idx_star` = 0, `Star_appear` = 0, `busy` = 0; synchroniser flops 0.
- `frame_clk` rising edge to `tick`: 2–3 `Clk`.
- `spawn` to `busy` = 1 and new position visible on outputs: 1 `Clk`.
- Pixel latency: `DrawX/DrawY` to `idx_star/Star_appear` is exactly 1 `Clk`.
  - One cycle for the synchronous ROM read; `in_box` and `vis` are registered alongside it.
  - Integration holds each pixel for ≥2 `Clk` (25 MHz pixel clock, 50 MHz `Clk`), so outputs are valid within the pixel.
- In IDLE: `idx_star` is forced to 0 and `Star_appear` = 0 regardless of ROM contents.

## Structure
- Shared game package holds:
  - `star_state_t` enum {IDLE, FLY, BLINK}
  - `SCREEN_W` = 640, `SCREEN_H` = 480
  - the 4-bit palette index type shared with the colour-mapper palettes
- Sub-module `star_rom`: 256×4 synchronous-read ROM initialised from the star sprite memory file, addressed {dy, dx}. The star uses the Kirby palette.
- Target size: about 150–250 lines of RTL excluding the ROM image.

## Test plan
- Reset mid-flight: spawn at (100, 200), 5 ticks, then assert `Reset` → `busy` = 0, `Star_appear` = 0, `idx_star` = 0, `star_x` = 0 immediately (asynchronous).
- Spawn (100, 200), dir 0, then 10 frame_clk pulses → `star_x` = 130, `star_y` = 200, state FLY. Pixel (DrawX, DrawY) = (138, 208) → `idx_star` = ROM[0x88] one `Clk` later. Pixel (146, 208) → `idx_star` = 0.
- Lifetime: spawn at (300, 100), 40 ticks → BLINK. `Star_appear` = 0 during `life_cnt` 44–47, = 1 during 48–51. After tick 60 → IDLE, `busy` = 0.
- Left exit: spawn x = 5, dir 1 → first tick moves to 2; second tick → IDLE with `star_x` remaining 2.
- Retrigger race: at `life_cnt` = 30, `spawn` coincides with `tick`, spawn at (50, 50) → `star_x` = 50 (not moved), `life_cnt` = 0, state FLY.
- Right edge: spawn x = 622, dir 0 → first tick → IDLE, since 625 > 624.
